seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits: operation select, 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of RV32M).
REQ-006 The block SHALL have port dividend, input, WIDTH bits: numerator, sampled with start.
REQ-007 The block SHALL have port divisor, input, WIDTH bits: denominator, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the cycle after start acceptance until done is asserted.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: quotient or remainder per op.

Function
REQ-011 The block SHALL use states IDLE, CALC, FIX and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch op, dividend and divisor and enter CALC.
- For signed ops, operands are latched as absolute values, with the quotient sign and remainder sign recorded.
REQ-013 CALC SHALL run a restoring division producing one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
- Each cycle: partial remainder = {rem, next dividend bit}.
- Subtract divisor using a WIDTH+1-bit subtractor.
- Keep the difference and shift in 1 when it is non-negative; otherwise restore and shift in 0.
REQ-014 FIX SHALL last exactly one cycle and select the result.
- Sign correction: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- Special-case overrides per REQ-016 and REQ-017.
REQ-015 DONE SHALL last one cycle with done=1, then return to IDLE.
- Latency: start accepted at edge E0 gives done=1 in the cycle following edge E0+WIDTH+1, i.e. WIDTH+2 cycles.
- Latency is identical for all ops and all operand values.
REQ-016 Divisor zero SHALL give quotient all-ones (both DIV and DIVU) and remainder equal to the original dividend.
REQ-017 Signed overflow (dividend = 1 followed by WIDTH-1 zeros, divisor all-ones, DIV/REM) SHALL give quotient = dividend and remainder 0.
REQ-018 result SHALL hold its value from the DONE cycle until the next accepted start; it SHALL NOT change during CALC/FIX.
REQ-019 start while busy=1 or in DONE SHALL be ignored; operand changes after acceptance SHALL have no effect.
REQ-020 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE; done and busy SHALL never both be 1.
REQ-021 Back-to-back: start asserted in the cycle after DONE SHALL be accepted normally.

Reset
REQ-022 With rst=0 at a clock edge, the block SHALL enter IDLE with busy=0, done=0, result=0 and all internal registers cleared.
REQ-023 Reset asserted mid-operation (CALC/FIX/DONE) SHALL abort it; no done pulse SHALL follow for the aborted request.
REQ-024 start SHALL be ignored while rst=0.

Verification
REQ-025 DIVU 100/7 -> done 34 cycles after start, result 14; REMU same operands -> 2.
REQ-026 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
REQ-027 Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; REMU 5/0 -> 5; latency still 34.
REQ-028 Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-029 Second start pulsed at cycle 10 of a busy DIVU 100/7 -> ignored, single done with 14; rst=0 at cycle 20 -> busy=0, done=0, result=0, no later done.
REQ-030 Random signed/unsigned operands against a reference model: result matches, exactly one done per accepted start, latency always WIDTH+2.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential RV32M-style divider: restoring division, one quotient bit per cycle.
// Fixed latency of WIDTH+2 cycles from start acceptance to the done pulse.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       fsm_state
);

    // Handshake: start is a request sampled only in IDLE; done is a one-cycle
    // valid pulse for result, which then holds until the next accepted start.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] orig_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             div0_q;
    logic             ovf_q;
    logic [WIDTH-1:0] result_q;

    logic             is_signed;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fix_result;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == LAST_BIT) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign fsm_state = state_q;

    // op[0]=0 selects the signed variants (DIV/REM).
    assign is_signed = ~op[0];
    assign dvd_neg   = is_signed & dividend[WIDTH-1];
    assign dvs_neg   = is_signed & divisor[WIDTH-1];
    assign dvd_abs   = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_abs   = dvs_neg ? (~divisor + 1'b1) : divisor;

    // Remainder stays below the divisor, so a WIDTH+1 bit difference cannot overflow.
    assign partial = {rem_q, quo_q[WIDTH-1]};
    assign diff    = partial - {1'b0, dvs_q};
    assign qbit    = ~diff[WIDTH];

    assign q_fix = neg_q_q ? (~quo_q + 1'b1) : quo_q;
    assign r_fix = neg_r_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        fix_result = op_q[1] ? r_fix : q_fix;
        if (div0_q)     fix_result = op_q[1] ? orig_q : {WIDTH{1'b1}};
        else if (ovf_q) fix_result = op_q[1] ? {WIDTH{1'b0}} : orig_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q     <= 2'b00;
            orig_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        orig_q  <= dividend;
                        quo_q   <= dvd_abs;
                        rem_q   <= '0;
                        dvs_q   <= dvs_abs;
                        cnt_q   <= '0;
                        neg_q_q <= dvd_neg ^ dvs_neg;
                        neg_r_q <= dvd_neg;
                        div0_q  <= (divisor == '0);
                        ovf_q   <= is_signed && (dividend == MIN_NEG) && (divisor == {WIDTH{1'b1}});
                    end
                end
                CALC: begin
                    // quo_q doubles as the dividend shift register: its MSB feeds the
                    // partial remainder while the new quotient bit enters at the LSB.
                    rem_q <= qbit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], qbit};
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    result_q <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signed/unsigned ops, divide-by-zero, overflow,
// ignored starts, mid-operation reset and a short random run against a reference.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  fsm_state;

    int          nvec;
    int          nerr;
    logic [31:0] last_exp;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFFFFFF;
        if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return o[1] ? 32'd0 : a;
        case (o)
            OP_DIV:  return $signed(a) / $signed(b);
            OP_DIVU: return a / b;
            OP_REM:  return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Called at a negedge; drives start in that cycle and returns at the negedge
    // one cycle after DONE, so consecutive calls exercise back-to-back starts.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int   k;
        logic seen;
        logic stable_ok;
        logic excl_ok;
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        k = 0; seen = 1'b0; stable_ok = 1'b1; excl_ok = 1'b1;
        while (!seen && k < 60) begin
            @(negedge clk);
            start    = 1'b0;
            op       = 2'($urandom_range(0, 3));
            dividend = $urandom;
            divisor  = $urandom;
            k++;
            if (busy && done) excl_ok = 1'b0;
            if (done) seen = 1'b1;
            else begin
                if (result !== last_exp) stable_ok = 1'b0;
                if (!busy) excl_ok = 1'b0;
            end
        end
        chk({tag, " latency"}, 32'(k), 32'd34);
        chk({tag, " result"}, result, exp);
        chk({tag, " result stable while busy"}, {31'd0, stable_ok}, 32'd1);
        chk({tag, " busy high and exclusive of done"}, {31'd0, excl_ok}, 32'd1);
        last_exp = exp;
        @(negedge clk);
        chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
        chk({tag, " result held"}, result, exp);
    endtask

    initial begin
        int          ndone;
        int          lat;
        logic [31:0] got;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        nvec = 0; nerr = 0; last_exp = 32'd0;
        rst = 1'b0; start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;

        // Reset with start held high must stay idle.
        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset state", {30'd0, fsm_state}, 32'd0);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("post-reset idle", {30'd0, fsm_state}, 32'd0);

        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, "divu 100/7");
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2, "remu 100/7");
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div -7/2");
        run_op(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem -7/2");
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, "div 7/-2");
        run_op(OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, "rem 7/-2");
        run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, "divu 5/0");
        run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, "div -5/0");
        run_op(OP_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, "rem -5/0");
        run_op(OP_REMU, 32'd5, 32'd0, 32'd5, "remu 5/0");
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div overflow");
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem overflow");
        run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, "divu 0x80000000/-1");
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, "divu max/max");
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, "divu max/1");
        run_op(OP_REMU, 32'h12345678, 32'h100, 32'h78, "remu 0x12345678/256");
        run_op(OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, "div -100/-7");
        run_op(OP_REM, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, "rem -100/-7");

        // Second start pulsed while busy must be ignored.
        op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk);
        ndone = 0; lat = 0; got = 32'd0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            start = (k == 10);
            if (k == 10) begin op = OP_DIV; dividend = 32'd1000; divisor = 32'd3; end
            if (done) begin ndone++; if (lat == 0) begin lat = k; got = result; end end
        end
        chk("ignored start done count", 32'(ndone), 32'd1);
        chk("ignored start latency", 32'(lat), 32'd34);
        chk("ignored start result", got, 32'd14);
        last_exp = 32'd14;

        // Reset at cycle 20 of an operation aborts it.
        op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort state", {30'd0, fsm_state}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", 32'(ndone), 32'd0);
        last_exp = 32'd0;

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            if (i == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; ro = OP_DIV; end
            run_op(ro, ra, rb, ref_model(ro, ra, rb), $sformatf("random %0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
